// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: pin side (row sense, column drive) and
// decoder side (accepted codes plus press/release events).
interface keypad_scanner_if;
  logic [3:0] kypd_row_in;
  logic [3:0] kypd_col_drv;
  logic [3:0] kypd_col;
  logic [3:0] kypd_row;
  logic       key_valid;
  logic       key_press;
  logic       key_release;

  modport master (
    input  kypd_row_in,
    output kypd_col_drv, kypd_col, kypd_row, key_valid, key_press, key_release
  );

  modport slave (
    output kypd_row_in,
    input  kypd_col_drv, kypd_col, kypd_row, key_valid, key_press, key_release
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad front end: column-by-column scan, 2-flop row synchronizer,
// whole-scan debounce, registered column/row codes and event pulses.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 3,
  parameter int DEBOUNCE_SCANS = 2
) (
  input logic             cclk,
  input logic             rst,
  keypad_scanner_if.master bus
);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int STB_W = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
  // A candidate is the {column code, row code} pair; all-ones means no key.
  localparam logic [7:0] NONE = 8'hFF;

  typedef enum logic {ST_SCAN, ST_EVAL} state_t;

  logic [3:0]       r_sync1, r_sync2;
  state_t           r_state;
  logic [1:0]       r_col_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_col_drv;
  logic [7:0]       r_cand, r_prev;
  logic [STB_W-1:0] r_stable;
  logic [3:0]       r_col, r_row;
  logic             r_valid, r_press, r_release;

  logic             w_hit;
  logic             w_last;
  logic [STB_W-1:0] w_stable_nxt;
  logic             w_settled;

  // Two-flop synchronizer on the asynchronous row pins.
  always_ff @(posedge cclk) begin
    if (rst) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= bus.kypd_row_in;
      r_sync2 <= r_sync1;
    end
  end

  // Hit detection and the debounce counter's next value for this EVAL.
  always_comb begin
    w_hit        = r_sync2 inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
    w_last       = (r_cnt == CNT_W'(SETTLE_CYCLES));
    w_stable_nxt = STB_W'(1);
    if (r_cand == r_prev)
      w_stable_nxt = (r_stable == STB_W'(DEBOUNCE_SCANS)) ? r_stable : r_stable + STB_W'(1);
    w_settled    = (w_stable_nxt == STB_W'(DEBOUNCE_SCANS));
  end

  // Scan/eval FSM with all outputs registered.
  always_ff @(posedge cclk) begin
    if (rst) begin
      r_state   <= ST_SCAN;
      r_col_idx <= 2'd0;
      r_cnt     <= '0;
      r_col_drv <= 4'b1110;
      r_cand    <= NONE;
      r_prev    <= NONE;
      r_stable  <= '0;
      r_col     <= 4'hF;
      r_row     <= 4'hF;
      r_valid   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      unique case (r_state)
        ST_SCAN: begin
          if (w_last) begin
            r_cnt <= '0;
            // First hit in column order wins; the drive pattern is the column code.
            if (r_cand == NONE && w_hit)
              r_cand <= {r_col_drv, r_sync2};
            if (r_col_idx == 2'd3) begin
              r_state   <= ST_EVAL;
              r_col_drv <= 4'hF;
            end else begin
              r_col_idx <= r_col_idx + 2'd1;
              r_col_drv <= {r_col_drv[2:0], r_col_drv[3]};
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_EVAL: begin
          r_state   <= ST_SCAN;
          r_col_idx <= 2'd0;
          r_cnt     <= '0;
          r_col_drv <= 4'b1110;
          r_cand    <= NONE;
          r_prev    <= r_cand;
          r_stable  <= w_stable_nxt;
          // Release takes priority; a new key is pressed one scan later.
          if (w_settled) begin
            if (r_valid && r_cand != {r_col, r_row}) begin
              r_release <= 1'b1;
              r_valid   <= 1'b0;
            end else if (!r_valid && r_cand != NONE) begin
              r_col   <= r_cand[7:4];
              r_row   <= r_cand[3:0];
              r_valid <= 1'b1;
              r_press <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.kypd_col_drv = r_col_drv;
  assign bus.kypd_col     = r_col;
  assign bus.kypd_row     = r_row;
  assign bus.key_valid    = r_valid;
  assign bus.key_press    = r_press;
  assign bus.key_release  = r_release;
endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized and directed bench for keypad_scanner with a scan-level
// reference model feeding a scoreboard of expected press/release events.
module tb_keypad_scanner;
  localparam int S   = 3;
  localparam int DEB = 2;
  localparam int P   = 4 * (S + 1) + 1;

  logic cclk = 1'b0;
  logic rst  = 1'b1;
  logic [15:0] keys = 16'h0;   // bit c*4+r = key (col c, row r) pressed

  keypad_scanner_if bus ();
  keypad_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_SCANS(DEB)) dut (
    .cclk(cclk), .rst(rst), .bus(bus)
  );

  always #5 cclk = ~cclk;

  // Keypad matrix: a pressed key shorts its driven-low column to its row.
  always_comb begin
    bus.kypd_row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!bus.kypd_col_drv[c] && keys[c*4+r]) bus.kypd_row_in[r] = 1'b0;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_press = 0, n_release = 0, last_press_cyc = -1;

  typedef struct { int cyc; bit press; logic [7:0] code; } ev_t;
  ev_t q[$];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Cycle index since the last reset edge.
  always @(posedge cclk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Reference model: key history per cycle, evaluated one whole scan at a time.
  logic [15:0] hist [64];
  logic [7:0]  m_prev, m_acc;
  int          m_stable;
  bit          m_valid;

  always @(negedge cclk) begin
    if (rst) begin
      m_prev = 8'hFF; m_acc = 8'hFF; m_stable = 0; m_valid = 0;
      q.delete();
    end else begin
      hist[cyc % 64] = keys;
      if (cyc % P == P - 1) begin
        logic [7:0] cand;
        cand = 8'hFF;
        for (int c = 0; c < 4; c++) begin
          logic [15:0] k;
          logic [3:0]  rows, ccode;
          int ts;
          ts    = (cyc - (P - 1)) + c * (S + 1) + S - 2;
          k     = hist[ts % 64] >> (c * 4);
          rows  = k[3:0];
          ccode = 4'b0001 << c;
          if ($countones(rows) == 1 && cand == 8'hFF) cand = {~ccode, ~rows};
        end
        if (cand == m_prev) m_stable = (m_stable >= DEB) ? DEB : m_stable + 1;
        else                m_stable = 1;
        m_prev = cand;
        if (m_stable == DEB) begin
          if (m_valid && cand != m_acc) begin
            q.push_back('{cyc: cyc + 1, press: 1'b0, code: m_acc});
            m_valid = 0;
          end else if (!m_valid && cand != 8'hFF) begin
            m_acc = cand;
            m_valid = 1;
            q.push_back('{cyc: cyc + 1, press: 1'b1, code: cand});
          end
        end
      end
    end
  end

  // Monitor: column drive sequence, pulses against the scoreboard.
  always @(negedge cclk) begin
    if (!rst) begin
      int ph;
      logic [3:0] exp_drv, one;
      ph  = cyc % P;
      one = 4'b0001 << (ph / (S + 1));
      exp_drv = (ph == P - 1) ? 4'hF : ~one;
      check("col_drv", bus.kypd_col_drv, exp_drv);
      if (bus.key_press)   begin n_press++; last_press_cyc = cyc; end
      if (bus.key_release) n_release++;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        ev_t e;
        e = q.pop_front();
        check("pulse_kind", {bus.key_press, bus.key_release}, e.press ? 2 : 1);
        check("event_code", {bus.kypd_col, bus.kypd_row}, e.code);
        check("event_valid", bus.key_valid, e.press ? 1 : 0);
      end else begin
        check("spurious_pulse", {bus.key_press, bus.key_release}, 0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge cclk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_drv"},   bus.kypd_col_drv, 4'hE);
    check({tag, "_codes"}, {bus.kypd_col, bus.kypd_row}, 8'hFF);
    check({tag, "_pulses"}, {bus.key_valid, bus.key_press, bus.key_release}, 0);
  endtask

  // Holds rst for n edges with keys as currently set; returns at cycle 0.
  task automatic do_reset(input int n);
    rst = 1'b1;
    step(n);
    check_reset_vals("reset");
    rst = 1'b0;
    last_press_cyc = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, r0;
    step(1);
    // Reset and idle scanning.
    keys = 16'h0;
    do_reset(3);
    step(10 * P);
    check("idle_press", n_press, 0);
    check("idle_release", n_release, 0);

    // Clean press of (1,2) held from cycle 0.
    keys = 16'h0040;
    do_reset(1);
    step(36);
    check("clean_press_cyc", last_press_cyc, 34);
    check("clean_codes", {bus.kypd_col, bus.kypd_row}, 8'hDB);
    check("clean_valid", bus.key_valid, 1);

    // Release.
    r0 = n_release;
    keys = 16'h0;
    step(3 * P);
    check("release_count", n_release - r0, 1);
    check("release_valid", bus.key_valid, 0);
    check("release_codes", {bus.kypd_col, bus.kypd_row}, 8'hDB);

    // Bounce on (3,0) from cycle 0, then hold.
    keys = 16'h0;
    do_reset(1);
    p0 = n_press;
    for (int i = 0; i < 60; i++) begin
      keys = ((i / 7) % 2 == 0) ? 16'h1000 : 16'h0;
      step(1);
    end
    keys = 16'h1000;
    step(6 * P);
    check("bounce_presses", n_press - p0, 1);
    check("bounce_codes", {bus.kypd_col, bus.kypd_row}, 8'h7E);
    keys = 16'h0;
    step(4 * P);

    // Two keys in different columns: first column wins.
    keys = 16'h0801;
    step(4 * P);
    check("multi_codes", {bus.kypd_col, bus.kypd_row}, 8'hEE);
    check("multi_valid", bus.key_valid, 1);
    keys = 16'h0;
    step(4 * P);
    // Two rows in one column: ignored.
    p0 = n_press;
    keys = 16'h0030;
    step(4 * P);
    check("multirow_press", n_press - p0, 0);
    check("multirow_valid", bus.key_valid, 0);

    // Reset mid-scan while a key is accepted.
    keys = 16'h0200;
    step(4 * P);
    check("pre_rst_valid", bus.key_valid, 1);
    step(5);
    r0 = n_release;
    do_reset(1);
    step(36);
    check("rst_no_release", n_release - r0, 0);
    check("rst_press_cyc", last_press_cyc, 34);

    // Randomized key activity checked by the scoreboard.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: keys = 16'h0;
        1, 2: keys = 16'h1 << $urandom_range(0, 15);
        default: keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      endcase
      step($urandom_range(3, 60));
    end

    keys = 16'h0;
    step(5 * P);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Front-end stage for the 4x4 matrix keypad. It drives the keypad column lines one at a time and samples the row lines through a synchronizer. It debounces across whole scans and presents a stable active-low column/row code pair on `kypd_col`/`kypd_row` to the keypad decoder, plus press/release event pulses. It sits between the keypad pins and the decoder, which maps the held column/row pair to a hex key value.

## Interface
- `SETTLE_CYCLES`, default 3: cycles a column is driven before its row sample is taken; legal range ≥ 2, which covers the 2-flop synchronizer.
- `DEBOUNCE_SCANS`, default 2: consecutive full scans with an identical candidate required before it is accepted; legal range ≥ 1.
- `cclk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `kypd_row_in`  in  4  raw row pins; active low, externally pulled up, asynchronous.
- `kypd_col_drv`  out  4  column pin drive; exactly one bit low while scanning.
- `kypd_col`  out  4  accepted key column code: 1110, 1101, 1011 or 0111 (col 0..3).
- `kypd_row`  out  4  accepted key row code: 1110, 1101, 1011 or 0111 (row 0..3).
- `key_valid`  out  1  high while an accepted key is held.
- `key_press`  out  1  one-cycle pulse when a key is accepted.
- `key_release`  out  1  one-cycle pulse when the accepted key is released or changes.

## Operation
- Row input passes through a 2-flop synchronizer. Flops reset to 1111.
- FSM states are SCAN (column index 0..3, settle counter) and EVAL.
- SCAN, column c:
  - `kypd_col_drv` = ~(1<<c) for SETTLE_CYCLES+1 cycles.
  - On the last cycle the synchronized row is sampled.
  - A sample is a hit only if it has exactly one zero bit. Samples of 1111 or with multiple zeros are ignored for that column.
  - The first hit in scan order (column 0 first) becomes the scan candidate. Later hits in the same scan are discarded.
  - After column 3 the FSM goes to EVAL.
- EVAL (1 cycle):
  - `kypd_col_drv` = 1111.
  - Candidate is an (col, row) pair, or NONE if the scan had no hit.
  - If candidate == previous scan candidate, stable_cnt increments, saturating at DEBOUNCE_SCANS. Otherwise stable_cnt = 1.
  - Previous candidate ← candidate.
  - If stable_cnt (new value) == DEBOUNCE_SCANS:
    - If `key_valid`=1 and candidate ≠ accepted key (including NONE): pulse `key_release`, clear `key_valid`. `kypd_col`/`kypd_row` retain their last values.
    - Else if `key_valid`=0 and candidate ≠ NONE: load `kypd_col`/`kypd_row`, set `key_valid`, pulse `key_press`.
  - Key-to-key change: release at one EVAL, press of the new key at the next EVAL (one scan later). Never both in one cycle.
  - After EVAL, scanning returns to column 0.
- Reset values:
  - `kypd_col_drv`=1110
  - `kypd_col`=1111, `kypd_row`=1111
  - `key_valid`=0, `key_press`=0, `key_release`=0
  - FSM in SCAN at column 0 with counter 0
  - previous candidate NONE, stable_cnt 0
- Reset asserted mid-scan or mid-EVAL: all state returns to the reset values on the next edge. No pulse is emitted.

## Timing
- Cycle numbering: cycle 0 is the first cycle after `rst` deasserts.
- Scan period P = 4·(SETTLE_CYCLES+1)+1 cycles (17 at defaults).
- Column c is driven during cycles c·(S+1) .. c·(S+1)+S, where S = SETTLE_CYCLES. The row sample is taken on cycle c·(S+1)+S and reflects the pins at cycle c·(S+1)+S−2.
- EVAL of scan k (k=0,1,…) occurs on cycle k·P+P−1. Output updates are visible on the following cycle.
- Press latency from a key held from cycle 0: `key_press` is high on cycle DEBOUNCE_SCANS·P (34 at defaults).
- `key_press` and `key_release` are each high for exactly 1 cycle and never high together.
- All outputs are registered. There are no combinational paths from `kypd_row_in`.

## Test plan
- Defaults apply (P=17). The bench keypad model pulls row r low while `kypd_col_drv` bit c is low and key (c,r) is pressed.
- Reset check:
  - Stimulus: `rst` high 3 cycles, no key.
  - Response: reset values on all outputs. `kypd_col_drv` = 1110×4, 1101×4, 1011×4, 0111×4, 1111×1, repeating. No pulses over 10 scans.
- Clean press:
  - Stimulus: key (col1,row2) held from cycle 0.
  - Response: `key_press` high only on cycle 34. Then `kypd_col`=1101, `kypd_row`=1011, `key_valid`=1.
- Release:
  - Stimulus: after the clean-press acceptance, release the key.
  - Response: exactly one `key_release` pulse 1–2 scans later. `key_valid`=0. `kypd_col`/`kypd_row` stay 1101/1011.
- Bounce:
  - Stimulus: toggle key (col3,row0) every 7 cycles for 60 cycles, then hold.
  - Response: no `key_press` until two consecutive scans agree. Exactly one press total, with codes 0111/1110.
- Multiple keys:
  - Stimulus: keys (col0,row0) and (col2,row3) held together.
  - Response: accepted codes 1110/1110.
  - Stimulus: keys (col1,row0) and (col1,row1) held, giving row sample 1100.
  - Response: column ignored, no press.
- Reset mid-operation:
  - Stimulus: key held and accepted, then `rst` pulsed for 1 cycle mid-scan.
  - Response: reset values the next cycle, with no `key_release` pulse. `key_press` fires again on cycle 34 after reset release.
